// File: rtl/fifo_pkg.sv
// Shared constants and read-mode enum for the programmable synchronous FIFO.
package fifo_pkg;

    typedef enum logic {STD = 1'b0, FWFT = 1'b1} read_mode_e;

    localparam int DEF_DATASIZE   = 8;
    localparam int DEF_ADDRSIZE   = 4;
    localparam int DEF_DEPTH      = 1 << DEF_ADDRSIZE;
    localparam int DEF_AFULL_THR  = DEF_DEPTH - 2;
    localparam int DEF_AEMPTY_THR = 2;

    function automatic int depth_of(input int addrsize);
        return 1 << addrsize;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the FIFO: one synchronous write port, one combinational read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATASIZE = DEF_DATASIZE,
    parameter int ADDRSIZE = DEF_ADDRSIZE
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [ADDRSIZE-1:0] waddr_i,
    input  logic [DATASIZE-1:0] wdata_i,
    input  logic [ADDRSIZE-1:0] raddr_i,
    output logic [DATASIZE-1:0] rdata_o
);

    localparam int DEPTH = depth_of(ADDRSIZE);

    // Contents are deliberately left unreset; pointers define what is valid.
    logic [DATASIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-full/empty thresholds, occupancy count,
// sticky overflow/underflow flags and selectable registered or fall-through read.
module sync_fifo_prog #(
    parameter int DATASIZE = fifo_pkg::DEF_DATASIZE,
    parameter int ADDRSIZE = fifo_pkg::DEF_ADDRSIZE,
    parameter int FWFT     = 0
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    input  logic [DATASIZE-1:0] WDATA_I,
    input  logic                WINC_I,
    output logic                WFULL_O,
    input  logic                RINC_I,
    output logic [DATASIZE-1:0] RDATA_O,
    output logic                REMPTY_O,
    input  logic [ADDRSIZE:0]   AFULL_THR_I,
    input  logic [ADDRSIZE:0]   AEMPTY_THR_I,
    output logic                AFULL_O,
    output logic                AEMPTY_O,
    output logic [ADDRSIZE:0]   COUNT_O,
    output logic                OVF_O,
    output logic                UDF_O,
    input  logic                CLR_ERR_I
);

    localparam fifo_pkg::read_mode_e MODE = (FWFT != 0) ? fifo_pkg::FWFT : fifo_pkg::STD;
    localparam logic [ADDRSIZE:0] DEPTH_C = {1'b1, {ADDRSIZE{1'b0}}};
    localparam logic [ADDRSIZE:0] ONE     = {{ADDRSIZE{1'b0}}, 1'b1};

    logic [ADDRSIZE:0]   wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
    logic                ovf_q, ovf_d, udf_q, udf_d;
    logic                full, empty, wr_en, rd_en;
    logic [DATASIZE-1:0] mem_rdata;

    always_comb begin
        full    = (count_q == DEPTH_C);
        empty   = (count_q == '0);
        // A write while full is rejected even if a read frees a slot this cycle.
        wr_en   = WINC_I && !full;
        rd_en   = RINC_I && !empty;
        wptr_d  = wr_en ? wptr_q + ONE : wptr_q;
        rptr_d  = rd_en ? rptr_q + ONE : rptr_q;
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
        // A new error event in the same cycle as a clear keeps the flag set.
        ovf_d = CLR_ERR_I ? 1'b0 : ovf_q;
        udf_d = CLR_ERR_I ? 1'b0 : udf_q;
        if (WINC_I && full)  ovf_d = 1'b1;
        if (RINC_I && empty) udf_d = 1'b1;
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    fifo_mem #(
        .DATASIZE(DATASIZE),
        .ADDRSIZE(ADDRSIZE)
    ) u_mem (
        .clk_i   (CLK_I),
        .we_i    (wr_en),
        .waddr_i (wptr_q[ADDRSIZE-1:0]),
        .wdata_i (WDATA_I),
        .raddr_i (rptr_q[ADDRSIZE-1:0]),
        .rdata_o (mem_rdata)
    );

    if (MODE == fifo_pkg::STD) begin : g_std
        logic [DATASIZE-1:0] rdata_q, rdata_d;

        assign rdata_d = rd_en ? mem_rdata : rdata_q;

        always_ff @(posedge CLK_I or posedge RST_I) begin
            if (RST_I) rdata_q <= '0;
            else       rdata_q <= rdata_d;
        end

        assign RDATA_O = rdata_q;
    end else begin : g_fwft
        assign RDATA_O = mem_rdata;
    end

    assign WFULL_O  = full;
    assign REMPTY_O = empty;
    // COUNT_O never exceeds DEPTH, so a threshold above DEPTH keeps AFULL_O low.
    assign AFULL_O  = (count_q >= AFULL_THR_I);
    assign AEMPTY_O = (count_q <= AEMPTY_THR_I);
    assign COUNT_O  = count_q;
    assign OVF_O    = ovf_q;
    assign UDF_O    = udf_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed self-checking bench for sync_fifo_prog in registered and fall-through modes.
module tb_sync_fifo_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wdata = '0;
    logic       winc = 1'b0, rinc = 1'b0, clr = 1'b0;
    logic [4:0] afull_thr = 5'd14, aempty_thr = 5'd2;
    logic [7:0] rdata;
    logic       wfull, rempty, afull, aempty, ovf, udf;
    logic [4:0] count;

    logic [7:0] fw_wdata = '0;
    logic       fw_winc = 1'b0, fw_rinc = 1'b0;
    logic [7:0] fw_rdata;
    logic       fw_wfull, fw_rempty, fw_afull, fw_aempty, fw_ovf, fw_udf;
    logic [4:0] fw_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_prog #(.DATASIZE(8), .ADDRSIZE(4), .FWFT(0)) dut (
        .CLK_I(clk), .RST_I(rst), .WDATA_I(wdata), .WINC_I(winc), .WFULL_O(wfull),
        .RINC_I(rinc), .RDATA_O(rdata), .REMPTY_O(rempty),
        .AFULL_THR_I(afull_thr), .AEMPTY_THR_I(aempty_thr),
        .AFULL_O(afull), .AEMPTY_O(aempty), .COUNT_O(count),
        .OVF_O(ovf), .UDF_O(udf), .CLR_ERR_I(clr)
    );

    sync_fifo_prog #(.DATASIZE(8), .ADDRSIZE(4), .FWFT(1)) dut_fw (
        .CLK_I(clk), .RST_I(rst), .WDATA_I(fw_wdata), .WINC_I(fw_winc), .WFULL_O(fw_wfull),
        .RINC_I(fw_rinc), .RDATA_O(fw_rdata), .REMPTY_O(fw_rempty),
        .AFULL_THR_I(afull_thr), .AEMPTY_THR_I(aempty_thr),
        .AFULL_O(fw_afull), .AEMPTY_O(fw_aempty), .COUNT_O(fw_count),
        .OVF_O(fw_ovf), .UDF_O(fw_udf), .CLR_ERR_I(1'b0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++; if (count !== 5'd0)   begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (rempty !== 1'b1)  begin errors++; $display("FAIL reset_empty got=%b exp=1", rempty); end
        checks++; if (wfull !== 1'b0)   begin errors++; $display("FAIL reset_full got=%b exp=0", wfull); end
        checks++; if (rdata !== 8'h00)  begin errors++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
        checks++; if ({ovf, udf} !== 2'b00) begin errors++; $display("FAIL reset_errflags got=%b exp=00", {ovf, udf}); end
        checks++; if ({afull, aempty} !== 2'b01) begin errors++; $display("FAIL reset_almost got=%b exp=01", {afull, aempty}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            winc = 1'b1; wdata = 8'(i);
            step();
            checks++; if (count !== 5'(i)) begin errors++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, i); end
            checks++; if (wfull !== (i == 16)) begin errors++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, wfull, (i == 16)); end
            checks++; if (afull !== (i >= 14)) begin errors++; $display("FAIL fill_afull i=%0d got=%b exp=%b", i, afull, (i >= 14)); end
            checks++; if (aempty !== (i <= 2)) begin errors++; $display("FAIL fill_aempty i=%0d got=%b exp=%b", i, aempty, (i <= 2)); end
        end
        wdata = 8'h11;
        step();
        winc = 1'b0;
        checks++; if (ovf !== 1'b1)    begin errors++; $display("FAIL overflow_flag got=%b exp=1", ovf); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL overflow_count got=%0d exp=16", count); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 16; i++) begin
            rinc = 1'b1;
            step();
            checks++; if (rdata !== 8'(i)) begin errors++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, rdata, 8'(i)); end
            checks++; if (count !== 5'(16 - i)) begin errors++; $display("FAIL drain_count i=%0d got=%0d exp=%0d", i, count, 16 - i); end
            checks++; if (aempty !== ((16 - i) <= 2)) begin errors++; $display("FAIL drain_aempty i=%0d got=%b", i, aempty); end
        end
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", rempty); end
        step();
        rinc = 1'b0;
        checks++; if (udf !== 1'b1)    begin errors++; $display("FAIL underflow_flag got=%b exp=1", udf); end
        checks++; if (count !== 5'd0)  begin errors++; $display("FAIL underflow_count got=%0d exp=0", count); end
        checks++; if (rdata !== 8'h10) begin errors++; $display("FAIL underflow_rdata_hold got=%h exp=10", rdata); end
    endtask

    task automatic test_err_clear();
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++; if ({ovf, udf} !== 2'b00) begin errors++; $display("FAIL clr_both got=%b exp=00", {ovf, udf}); end
        for (int i = 0; i < 16; i++) begin
            winc = 1'b1; wdata = 8'(32'h20 + i);
            step();
        end
        winc = 1'b1; rinc = 1'b1; wdata = 8'hEE;
        step();
        rinc = 1'b0;
        checks++; if (count !== 5'd15) begin errors++; $display("FAIL full_wr_rd_count got=%0d exp=15", count); end
        checks++; if (rdata !== 8'h20) begin errors++; $display("FAIL full_wr_rd_data got=%h exp=20", rdata); end
        checks++; if (ovf !== 1'b1)    begin errors++; $display("FAIL full_wr_rd_ovf got=%b exp=1", ovf); end
        wdata = 8'h30;
        step();
        clr = 1'b1; wdata = 8'hEF;
        step();
        winc = 1'b0;
        checks++; if (ovf !== 1'b1)    begin errors++; $display("FAIL clr_vs_ovf got=%b exp=1", ovf); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL clr_vs_ovf_count got=%0d exp=16", count); end
        step();
        clr = 1'b0;
        checks++; if (ovf !== 1'b0)    begin errors++; $display("FAIL clr_alone got=%b exp=0", ovf); end
        for (int i = 1; i <= 16; i++) begin
            rinc = 1'b1;
            step();
            checks++; if (rdata !== 8'(32'h20 + i)) begin errors++; $display("FAIL err_drain i=%0d got=%h exp=%h", i, rdata, 8'(32'h20 + i)); end
        end
        rinc = 1'b0;
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL err_drain_empty got=%b exp=1", rempty); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            winc = 1'b1; wdata = 8'(32'h40 + i);
            step();
        end
        winc = 1'b0;
        checks++; if (count !== 5'd5) begin errors++; $display("FAIL b2b_prefill got=%0d exp=5", count); end
        for (int k = 0; k < 40; k++) begin
            winc = 1'b1; rinc = 1'b1; wdata = 8'(32'h45 + k);
            step();
            checks++; if (rdata !== 8'(32'h40 + k)) begin errors++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, rdata, 8'(32'h40 + k)); end
            checks++; if (count !== 5'd5) begin errors++; $display("FAIL b2b_count k=%0d got=%0d exp=5", k, count); end
        end
        winc = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rinc = 1'b1;
            step();
            checks++; if (rdata !== 8'(32'h68 + i)) begin errors++; $display("FAIL b2b_tail i=%0d got=%h exp=%h", i, rdata, 8'(32'h68 + i)); end
        end
        rinc = 1'b0;
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL b2b_empty got=%b exp=1", rempty); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 9; i++) begin
            winc = 1'b1; wdata = 8'(32'h80 + i);
            step();
        end
        winc = 1'b0;
        checks++; if (count !== 5'd9) begin errors++; $display("FAIL arst_prefill got=%0d exp=9", count); end
        rst = 1'b1;
        #1;
        checks++; if (count !== 5'd0)  begin errors++; $display("FAIL arst_count got=%0d exp=0", count); end
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL arst_empty got=%b exp=1", rempty); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL arst_rdata got=%h exp=00", rdata); end
        checks++; if ({wfull, ovf, udf} !== 3'b000) begin errors++; $display("FAIL arst_flags got=%b exp=000", {wfull, ovf, udf}); end
        #1;
        rst = 1'b0; winc = 1'b1; wdata = 8'h99;
        step();
        winc = 1'b0;
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL arst_first_write got=%0d exp=1", count); end
        rinc = 1'b1;
        step();
        checks++; if (rdata !== 8'h99) begin errors++; $display("FAIL arst_new_data got=%h exp=99", rdata); end
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL arst_post_empty got=%b exp=1", rempty); end
        clr = 1'b1;
        step();
        checks++; if (udf !== 1'b1) begin errors++; $display("FAIL clr_vs_udf got=%b exp=1", udf); end
        rinc = 1'b0;
        step();
        clr = 1'b0;
        checks++; if (udf !== 1'b0) begin errors++; $display("FAIL clr_udf got=%b exp=0", udf); end
    endtask

    task automatic test_fwft();
        checks++; if (fw_rempty !== 1'b1) begin errors++; $display("FAIL fwft_initial_empty got=%b exp=1", fw_rempty); end
        fw_winc = 1'b1; fw_wdata = 8'hA5;
        step();
        fw_winc = 1'b0;
        checks++; if (fw_rdata !== 8'hA5) begin errors++; $display("FAIL fwft_data got=%h exp=a5", fw_rdata); end
        checks++; if (fw_rempty !== 1'b0) begin errors++; $display("FAIL fwft_not_empty got=%b exp=0", fw_rempty); end
        fw_rinc = 1'b1;
        step();
        fw_rinc = 1'b0;
        checks++; if (fw_rempty !== 1'b1) begin errors++; $display("FAIL fwft_pop_empty got=%b exp=1", fw_rempty); end
        fw_winc = 1'b1; fw_wdata = 8'h11;
        step();
        fw_wdata = 8'h22;
        step();
        fw_winc = 1'b0;
        checks++; if (fw_rdata !== 8'h11) begin errors++; $display("FAIL fwft_head got=%h exp=11", fw_rdata); end
        fw_rinc = 1'b1;
        step();
        checks++; if (fw_rdata !== 8'h22) begin errors++; $display("FAIL fwft_next got=%h exp=22", fw_rdata); end
        checks++; if (fw_count !== 5'd1) begin errors++; $display("FAIL fwft_count got=%0d exp=1", fw_count); end
        step();
        fw_rinc = 1'b0;
        checks++; if (fw_rempty !== 1'b1) begin errors++; $display("FAIL fwft_final_empty got=%b exp=1", fw_rempty); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_err_clear();
        test_back_to_back();
        test_async_reset();
        test_fwft();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
